// File: rtl/prog_loader.sv
// Serial program loader: parses a SYNC/COUNT/START/words/CHK byte frame, streams each
// word into the instruction cache, and on a good checksum launches the datapath at initPC.
module prog_loader #(
    parameter int         N     = 32,
    parameter int         DEPTH = 128,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               byteIn,
    input  logic                     byteValid,
    output logic                     byteReady,
    output logic                     prog,
    output logic [$clog2(DEPTH)-1:0] blockAddr,
    output logic [N-1:0]             Iword,
    output logic                     loadPC,
    output logic [29:0]              initPC,
    output logic                     done,
    output logic                     error
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        S_IDLE,
        S_COUNT,
        S_START,
        S_WORD,
        S_WRITE,
        S_CHECK,
        S_LAUNCH,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     count_q, count_d;
    logic [7:0]     index_q, index_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]     xor_q, xor_d;
    logic [31:0]    shift_q, shift_d;
    logic [AW-1:0]  block_addr_q, block_addr_d;
    logic [N-1:0]   iword_q, iword_d;
    logic [29:0]    init_pc_q, init_pc_d;
    logic           byte_ready_q, byte_ready_d;
    logic           prog_q, prog_d;
    logic           load_pc_q, load_pc_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    logic           accept;
    logic [31:0]    shift_next;
    logic [7:0]     xor_next;
    logic [7:0]     index_inc;
    logic           count_bad;

    always_comb begin
        accept     = byteValid && byte_ready_q;
        shift_next = {shift_q[23:0], byteIn};
        xor_next   = xor_q ^ byteIn;
        index_inc  = index_q + 8'd1;
        count_bad  = (byteIn == 8'd0) || ({24'd0, byteIn} > 32'(DEPTH));

        state_d      = state_q;
        count_d      = count_q;
        index_d      = index_q;
        byte_cnt_d   = byte_cnt_q;
        xor_d        = xor_q;
        shift_d      = shift_q;
        block_addr_d = block_addr_q;
        iword_d      = iword_q;
        init_pc_d    = init_pc_q;

        unique case (state_q)
            S_IDLE, S_ERR: begin
                // A SYNC byte always restarts a frame; anything else is dropped
                if (accept && byteIn == SYNC) begin
                    state_d    = S_COUNT;
                    xor_d      = 8'd0;
                    byte_cnt_d = 2'd0;
                    index_d    = 8'd0;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    count_d    = byteIn;
                    xor_d      = xor_next;
                    byte_cnt_d = 2'd0;
                    state_d    = count_bad ? S_ERR : S_START;
                end
            end
            S_START: begin
                if (accept) begin
                    shift_d    = shift_next;
                    xor_d      = xor_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (shift_next[1:0] != 2'b00) begin
                            state_d = S_ERR;
                        end else begin
                            init_pc_d = shift_next[31:2];
                            index_d   = 8'd0;
                            state_d   = S_WORD;
                        end
                    end
                end
            end
            S_WORD: begin
                if (accept) begin
                    shift_d    = shift_next;
                    xor_d      = xor_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                block_addr_d = index_q[AW-1:0];
                iword_d      = N'(shift_q);
                index_d      = index_inc;
                state_d      = (index_inc == count_q) ? S_CHECK : S_WORD;
            end
            S_CHECK: begin
                if (accept) begin
                    xor_d   = xor_next;
                    state_d = (xor_next == 8'd0) ? S_LAUNCH : S_ERR;
                end
            end
            S_LAUNCH: state_d = S_DONE;
            S_DONE:   state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with state_q
        byte_ready_d = !(state_d == S_WRITE || state_d == S_LAUNCH || state_d == S_DONE);
        prog_d       = !(state_d == S_LAUNCH || state_d == S_DONE);
        load_pc_d    = (state_d == S_LAUNCH);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            count_q      <= 8'd0;
            index_q      <= 8'd0;
            byte_cnt_q   <= 2'd0;
            xor_q        <= 8'd0;
            shift_q      <= 32'd0;
            block_addr_q <= '0;
            iword_q      <= '0;
            init_pc_q    <= 30'd0;
            byte_ready_q <= 1'b1;
            prog_q       <= 1'b1;
            load_pc_q    <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            byte_cnt_q   <= byte_cnt_d;
            xor_q        <= xor_d;
            shift_q      <= shift_d;
            block_addr_q <= block_addr_d;
            iword_q      <= iword_d;
            init_pc_q    <= init_pc_d;
            byte_ready_q <= byte_ready_d;
            prog_q       <= prog_d;
            load_pc_q    <= load_pc_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byteReady = byte_ready_q;
    assign prog      = prog_q;
    assign blockAddr = block_addr_q;
    assign Iword     = iword_q;
    assign loadPC    = load_pc_q;
    assign initPC    = init_pc_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter N, default 32, instruction word width.
REQ-002 Parameter DEPTH, default 128, instruction cache words; index width 7.
REQ-003 Parameter SYNC, default 8'hA5, frame start byte.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 byteIn  input  8  incoming serial byte from host.
REQ-007 byteValid  input  1  byteIn valid this cycle.
REQ-008 byteReady  output  1  loader can accept a byte; transfer occurs when byteValid & byteReady at posedge.
REQ-009 prog  output  1  drives the datapath programming mode: 1 = program the instruction cache, 0 = run.
REQ-010 blockAddr  output  7  instruction cache write index.
REQ-011 Iword  output  N  instruction cache write data.
REQ-012 loadPC  output  1  one-cycle pulse that loads initPC into the datapath PC.
REQ-013 initPC  output  30  start word address.
REQ-014 done  output  1  program loaded and launched.
REQ-015 error  output  1  frame rejected.

Function
REQ-016 The frame format SHALL be: SYNC, COUNT (1 byte), START (4 bytes, MSB first), COUNT words of 4 bytes each (MSB first), CHK (1 byte).
REQ-017 States SHALL be IDLE, COUNT, START, WORD, WRITE, CHECK, LAUNCH, DONE, ERR.
REQ-018 byteReady SHALL be 1 in IDLE, COUNT, START, WORD, CHECK and ERR, and 0 in WRITE, LAUNCH and DONE.
REQ-019 IDLE: an accepted byte equal to SYNC SHALL move to COUNT and clear the running XOR; any other accepted byte SHALL be discarded.
REQ-020 COUNT: the accepted byte SHALL be latched; a value of 0 or greater than DEPTH SHALL go to ERR, otherwise the state SHALL go to START.
REQ-021 START: four bytes SHALL be assembled into a 32-bit byte address.
REQ-022 If address[1:0] != 0 after the 4th START byte, the state SHALL go to ERR; otherwise initPC <= address[31:2] and the state SHALL go to WORD with word index = 0.
REQ-023 WORD: four bytes SHALL be assembled into a word; after the 4th byte the state SHALL go to WRITE.
REQ-024 WRITE, one cycle:
  - Iword <= assembled word, blockAddr <= index, both registered and updated together.
  - index SHALL increment.
  - If the incremented index == COUNT, the state SHALL go to CHECK; otherwise it SHALL go to WORD.
REQ-025 blockAddr and Iword SHALL hold their values in every state except WRITE, because the cache samples them on every clk while prog = 1.
REQ-026 index SHALL never wrap; with COUNT = DEPTH the last write SHALL use blockAddr = DEPTH-1.
REQ-027 The running XOR SHALL cover every accepted byte after SYNC, including CHK.
REQ-028 CHECK: after CHK is accepted, XOR == 0 SHALL go to LAUNCH; any other value SHALL go to ERR.
REQ-029 LAUNCH, one cycle: prog = 0, loadPC = 1, initPC stable; the next state SHALL be DONE.
REQ-030 DONE: prog = 0, loadPC = 0, done = 1; the state SHALL hold until rst.
REQ-031 ERR:
  - error = 1, prog = 1, loadPC = 0.
  - Non-SYNC bytes SHALL be drained.
  - An accepted SYNC SHALL clear error and the XOR and go to COUNT.
REQ-032 prog SHALL be 1 in every state except LAUNCH and DONE.
REQ-033 loadPC SHALL be 1 only in LAUNCH.
REQ-034 A byte presented while byteReady = 0 SHALL NOT be consumed or altered.

Reset
REQ-035 On rst = 1 at posedge, the following SHALL hold next cycle:
  - state = IDLE, prog = 1, loadPC = 0, done = 0, error = 0, byteReady = 1.
  - blockAddr = 0, Iword = 0, initPC = 0.
  - index, COUNT, byte counter and XOR = 0.
REQ-036 rst SHALL take priority over byte acceptance in the same cycle.
REQ-037 rst mid-frame SHALL abandon the frame; words already written SHALL remain in the cache.

Verification
REQ-038 Frame A5,01,00,00,00,10,20,08,00,05,3C -> blockAddr = 0 and Iword = 0x20080005 after WRITE; one cycle with loadPC = 1, prog = 0 and initPC = 0x00000004; then done = 1.
REQ-039 The same frame with CHK = 0x3D -> error = 1, prog stays 1, loadPC never asserts.
REQ-040 Frame A5,00 -> ERR immediately after the COUNT byte; a subsequent valid frame -> error clears and the frame loads normally.
REQ-041 START = 0x00000002 -> ERR after the 4th START byte; blockAddr and Iword unchanged.
REQ-042 COUNT = 0x80 with words equal to their index -> the last write has blockAddr = 127 and Iword = 0x0000007F with no wrap; launch occurs with the correct CHK.
REQ-043 Bytes 0x00, 0xFF before SYNC -> ignored; byteValid held high during WRITE -> the byte is consumed one cycle later, not twice; rst after the 2nd word -> prog = 1, blockAddr = 0, state = IDLE.
